// File: rtl/sd_pkg.sv
// Shared SD data-path constants: CRC polynomials, block size and the CRC engine state encoding.
package sd_pkg;

    localparam logic [15:0] CRC16_POLY     = 16'h1021;
    localparam logic [6:0]  CRC7_POLY      = 7'h09;
    localparam int unsigned SD_BLOCK_BYTES = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        UNLOAD = 2'd2
    } crc_state_t;

endpackage

// File: rtl/crc_lane.sv
// One DAT line's serial CRC register: clear, update, MSB-first unload and optional compare.
// Received-CRC comparison is built only when CRC_LANES_CHECK_EN is defined.
module crc_lane
    import sd_pkg::*;
#(
    parameter int unsigned      CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC16_POLY)
) (
    input  logic iclk,
    input  logic irst_n,
    input  logic i_clear,
    input  logic i_update,
    input  logic i_shift,
    input  logic i_out_en,
    input  logic i_chk,
    input  logic i_data,
    output logic o_crc,
    output logic o_err
);

    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_nxt;
    logic [CRC_W-1:0] w_shl;
    logic             w_fb;
    logic             r_out;

    always_comb begin
        w_shl     = {r_crc[CRC_W-2:0], 1'b0};
        w_fb      = i_data ^ r_crc[CRC_W-1];
        w_crc_nxt = r_crc;
        if (i_clear) begin
            w_crc_nxt = '0;
        end else if (i_update) begin
            w_crc_nxt = w_shl ^ (w_fb ? POLY : '0);
        end else if (i_shift) begin
            w_crc_nxt = w_shl;
        end
    end

    // Output bit is the MSB of the value the register is about to hold.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_crc <= '0;
            r_out <= 1'b0;
        end else begin
            r_crc <= w_crc_nxt;
            r_out <= i_out_en & w_crc_nxt[CRC_W-1];
        end
    end

    assign o_crc = r_out;

`ifdef CRC_LANES_CHECK_EN
    logic r_err;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_err <= 1'b0;
        end else if (i_clear) begin
            r_err <= 1'b0;
        end else if (i_chk && (i_data != r_crc[CRC_W-1])) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused;
    assign w_unused = i_chk;
    assign o_err    = 1'b0;
`endif

endmodule

// File: rtl/crc_lanes.sv
// Multi-lane serial CRC engine for the SD data path: block bit counting, FSM and CRC unload.
// Receive-side CRC checking (icheck, oerr) is built only when CRC_LANES_CHECK_EN is defined.
module crc_lanes
    import sd_pkg::*;
#(
    parameter int unsigned      LANES      = 4,
    parameter int unsigned      CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLY       = CRC_W'(CRC16_POLY),
    parameter int unsigned      BLOCK_BITS = 1024
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             istart,
    input  logic             icheck,
    input  logic             ivalid,
    input  logic [LANES-1:0] idata,
    output logic [LANES-1:0] ocrc,
    output logic             ocrc_valid,
    output logic             obusy,
    output logic             odone,
    output logic [LANES-1:0] oerr
);

    localparam int unsigned CNT_W = $clog2(BLOCK_BITS + 1);

    crc_state_t       r_state;
    crc_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;
    logic             r_crc_valid;
    logic             r_done;
    logic             w_clear;
    logic             w_update;
    logic             w_shift;
    logic             w_chk;
    logic             w_done_nxt;
    logic             w_out_en;

`ifdef CRC_LANES_CHECK_EN
    logic r_mode;
    logic w_mode_nxt;
`else
    logic w_unused;
    assign w_unused = icheck;
`endif

    // Next-state, counter and lane control.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clear     = 1'b0;
        w_update    = 1'b0;
        w_shift     = 1'b0;
        w_chk       = 1'b0;
        w_done_nxt  = 1'b0;
`ifdef CRC_LANES_CHECK_EN
        w_mode_nxt  = r_mode;
`endif
        case (r_state)
            IDLE: begin
                if (istart) begin
                    w_clear     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = CALC;
`ifdef CRC_LANES_CHECK_EN
                    w_mode_nxt  = icheck;
`endif
                end
            end
            CALC: begin
                if (ivalid) begin
                    w_update = 1'b1;
                    if (r_cnt == CNT_W'(BLOCK_BITS - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = UNLOAD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            UNLOAD: begin
                w_shift = 1'b1;
`ifdef CRC_LANES_CHECK_EN
                w_chk   = r_mode & ivalid;
`endif
                if (r_cnt == CNT_W'(CRC_W - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_out_en = (w_state_nxt == UNLOAD);
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_crc_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_crc_valid <= w_out_en;
            r_done      <= w_done_nxt;
        end
    end

`ifdef CRC_LANES_CHECK_EN
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_mode <= 1'b0;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        crc_lane #(
            .CRC_W (CRC_W),
            .POLY  (POLY)
        ) u_lane (
            .iclk     (iclk),
            .irst_n   (irst_n),
            .i_clear  (w_clear),
            .i_update (w_update),
            .i_shift  (w_shift),
            .i_out_en (w_out_en),
            .i_chk    (w_chk),
            .i_data   (idata[g]),
            .o_crc    (ocrc[g]),
            .o_err    (oerr[g])
        );
    end

    assign ocrc_valid = r_crc_valid;
    assign obusy      = r_busy;
    assign odone      = r_done;

endmodule
